// File: rtl/sync_fifo_wr_arb.sv
// ============================================================================
// sync_fifo_wr_arb
//
// Purpose:
//   Round-robin arbiter that lets NUM_REQ producers share the single write
//   port of a sync_fifo. The producer that wins arbitration keeps the port
//   for its whole packet, so beats from different producers never interleave
//   in the FIFO. A per-grant beat limit (MAX_BURST) forces a release so one
//   long packet cannot starve the other producers. A packet cut this way is
//   finished after the producer wins arbitration again.
//
// Optional feature (compile-time macro):
//   SYNC_FIFO_ARB_SRCID_EN - when defined, the index of the granted producer
//   is prepended to every beat written to the FIFO:
//   fifo_wdata_o = {owner index, payload}.
//
// Ports:
//   clk_i         in   1                   clock
//   resetn_i      in   1                   asynchronous active-low reset
//   req_valid_i   in   NUM_REQ             per-producer beat valid
//   req_last_i    in   NUM_REQ             per-producer last beat of packet
//   req_data_i    in   NUM_REQ*DATA_WIDTH  packed payloads, req i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o   out  NUM_REQ             beat accepted when valid & ready
//   fifo_wr_en_o  out  1                   FIFO write enable
//   fifo_wdata_o  out  FIFO_W              FIFO write data
//   fifo_wfull_i  in   1                   FIFO full flag
//   grant_o       out  NUM_REQ             one-hot current owner, 0 when idle
//   busy_o        out  1                   high while a grant is held
// ============================================================================
module sync_fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = 2,
    parameter int MAX_BURST  = 16,
`ifdef SYNC_FIFO_ARB_SRCID_EN
    localparam int FIFO_W    = DATA_WIDTH + IDX_W
`else
    localparam int FIFO_W    = DATA_WIDTH
`endif
) (
    input  logic                          clk_i,
    input  logic                          resetn_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          fifo_wr_en_o,
    output logic [FIFO_W-1:0]             fifo_wdata_o,
    input  logic                          fifo_wfull_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o
);

    // Sized so it can hold MAX_BURST without wrapping.
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic [0:0]            state_q,   state_d;
    logic [NUM_REQ-1:0]    grant_q,   grant_d;
    logic [IDX_W-1:0]      owner_q,   owner_d;
    logic [IDX_W-1:0]      lastIdx_q, lastIdx_d;
    logic [CNT_W-1:0]      beatCnt_q, beatCnt_d;

    logic [IDX_W-1:0]      pickIdx;
    logic                  pickValid;
    logic [DATA_WIDTH-1:0] ownerData;
    logic                  ownerValid;
    logic                  ownerLast;
    logic                  xfer;
    logic                  pktDone;

    // Round-robin search starting one past the previous owner, so after a
    // release that producer has the lowest priority. The first valid index
    // in that rotated order wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        pickIdx   = '0;
        pickValid = 1'b0;
        cand      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((int'(lastIdx_q) + off) % NUM_REQ);
            if (!pickValid && req_valid_i[cand]) begin
                pickValid = 1'b1;
                pickIdx   = cand;
            end
        end
    end

    // grant_q is one-hot in LOCK and zero in IDLE, so masking with it picks
    // out the owner's signals and gives 0 when no grant is held.
    always_comb begin
        ownerData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                ownerData = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign ownerValid = |(req_valid_i & grant_q);
    assign ownerLast  = |(req_last_i & grant_q);
    assign xfer       = ownerValid & ~fifo_wfull_i;
    // Release on the packet's last beat, or on the beat that reaches the
    // burst limit.
    assign pktDone    = xfer & (ownerLast | (beatCnt_q == CNT_W'(MAX_BURST - 1)));

    // Next-state logic: a grant is taken in IDLE and dropped only after a
    // completed transfer. Stalls (FIFO full, owner not valid) just hold.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        lastIdx_d = lastIdx_q;
        beatCnt_d = beatCnt_q;
        case (state_q)
            IDLE: begin
                if (pickValid) begin
                    state_d   = LOCK;
                    grant_d   = NUM_REQ'(1) << pickIdx;
                    owner_d   = pickIdx;
                    beatCnt_d = '0;
                end
            end
            LOCK: begin
                if (pktDone) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    lastIdx_d = owner_q;
                    beatCnt_d = '0;
                end else if (xfer) begin
                    beatCnt_d = beatCnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // lastIdx resets to the top index so that producer 0 wins first.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            lastIdx_q <= IDX_W'(NUM_REQ - 1);
            beatCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            lastIdx_q <= lastIdx_d;
            beatCnt_q <= beatCnt_d;
        end
    end

    assign grant_o      = grant_q;
    assign busy_o       = (state_q == LOCK);
    assign req_ready_o  = grant_q & {NUM_REQ{~fifo_wfull_i}};
    assign fifo_wr_en_o = xfer;

`ifdef SYNC_FIFO_ARB_SRCID_EN
    // owner_q keeps its old value in IDLE, so it is masked to hold the
    // write data at zero while no grant is held.
    assign fifo_wdata_o = (state_q == LOCK) ? {owner_q, ownerData} : '0;
`else
    assign fifo_wdata_o = ownerData;
`endif

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// ============================================================================
// tb_sync_fifo_wr_arb
//
// Purpose:
//   Self-checking bench for sync_fifo_wr_arb. It uses a table of hand-computed
//   vectors, short hand-written sequences for the multi-cycle cases, and a
//   randomized run compared against a packet-level reference model.
//   It honours SYNC_FIFO_ARB_SRCID_EN in the same way as the design.
// ============================================================================
module tb_sync_fifo_wr_arb;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 16;
    localparam int IDX_W      = 2;
    localparam int MAX_BURST  = 16;
`ifdef SYNC_FIFO_ARB_SRCID_EN
    localparam int FIFO_W            = DATA_WIDTH + IDX_W;
    localparam logic [31:0] T6_EXP   = 32'h0003_1234;
`else
    localparam int FIFO_W            = DATA_WIDTH;
    localparam logic [31:0] T6_EXP   = 32'h0000_1234;
`endif

    logic                          clk_i = 1'b0;
    logic                          resetn_i;
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ-1:0]            req_last_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic                          fifo_wr_en_o;
    logic [FIFO_W-1:0]             fifo_wdata_o;
    logic                          fifo_wfull_i;
    logic [NUM_REQ-1:0]            grant_o;
    logic                          busy_o;

    sync_fifo_wr_arb #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk_i        (clk_i),
        .resetn_i     (resetn_i),
        .req_valid_i  (req_valid_i),
        .req_last_i   (req_last_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .fifo_wr_en_o (fifo_wr_en_o),
        .fifo_wdata_o (fifo_wdata_o),
        .fifo_wfull_i (fifo_wfull_i),
        .grant_o      (grant_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [63:0] data;
        logic        full;
        logic [3:0]  expGrant;
        logic [3:0]  expReady;
        logic        expWrEn;
        logic [15:0] expPayload;
        logic        expBusy;
    } vec_t;

    vec_t vecs[16];

    int vecCount  = 0;
    int missCount = 0;

    // Packet-level reference state: owner (-1 when idle), previous owner and
    // beats moved under the current grant.
    int mOwner;
    int mLast;
    int mBeats;

    logic [FIFO_W-1:0] fifoCap[$];

    function automatic vec_t mkVec(logic rst, logic [3:0] valid, logic [3:0] last,
                                   logic [63:0] data, logic full, logic [3:0] expGrant,
                                   logic [3:0] expReady, logic expWrEn,
                                   logic [15:0] expPayload, logic expBusy);
        vec_t v;
        v.rst        = rst;
        v.valid      = valid;
        v.last       = last;
        v.data       = data;
        v.full       = full;
        v.expGrant   = expGrant;
        v.expReady   = expReady;
        v.expWrEn    = expWrEn;
        v.expPayload = expPayload;
        v.expBusy    = expBusy;
        return v;
    endfunction

    function automatic logic [63:0] packData(int idx, logic [15:0] value);
        logic [63:0] d;
        d = '0;
        d[idx*16 +: 16] = value;
        return d;
    endfunction

    function automatic int oneHotIdx(logic [3:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) r = i;
        end
        return r;
    endfunction

    function automatic logic [FIFO_W-1:0] expWdata(int idx, logic [15:0] payload);
`ifdef SYNC_FIFO_ARB_SRCID_EN
        return {IDX_W'(idx), payload};
`else
        return (idx < 0) ? '0 : payload;
`endif
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge and outputs are sampled 1ns later,
    // well away from the rising edge that updates the design.
    task automatic applyStimulus(logic [3:0] v, logic [3:0] l, logic [63:0] d, logic f);
        @(negedge clk_i);
        req_valid_i  = v;
        req_last_i   = l;
        req_data_i   = d;
        fifo_wfull_i = f;
        #1;
    endtask

    task automatic captureBeat();
        if (fifo_wr_en_o === 1'b1) fifoCap.push_back(fifo_wdata_o);
    endtask

    task automatic modelReset();
        mOwner = -1;
        mLast  = NUM_REQ - 1;
        mBeats = 0;
    endtask

    // Compare the outputs with the model's view of the current cycle, then
    // step the model across the coming rising edge.
    task automatic modelCheck(string tag);
        logic [3:0]        eGrant;
        logic [3:0]        eReady;
        logic              eWr;
        logic [FIFO_W-1:0] eData;
        eGrant = '0;
        eReady = '0;
        eWr    = 1'b0;
        eData  = '0;
        if (mOwner >= 0) begin
            eGrant[mOwner] = 1'b1;
            if (!fifo_wfull_i) eReady = eGrant;
            eWr   = req_valid_i[mOwner] & ~fifo_wfull_i;
            eData = expWdata(mOwner, req_data_i[mOwner*16 +: 16]);
        end
        checkOutput({tag, ".grant"}, 32'(grant_o), 32'(eGrant));
        checkOutput({tag, ".ready"}, 32'(req_ready_o), 32'(eReady));
        checkOutput({tag, ".wrEn"},  32'(fifo_wr_en_o), 32'(eWr));
        checkOutput({tag, ".wdata"}, 32'(fifo_wdata_o), 32'(eData));
        checkOutput({tag, ".busy"},  32'(busy_o), 32'(mOwner >= 0));
        captureBeat();
        if (mOwner < 0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (mOwner < 0 && req_valid_i[(mLast + k) % NUM_REQ]) begin
                    mOwner = (mLast + k) % NUM_REQ;
                    mBeats = 0;
                end
            end
        end else if (eWr) begin
            mBeats++;
            if (req_last_i[mOwner] || mBeats == MAX_BURST) begin
                mLast  = mOwner;
                mOwner = -1;
                mBeats = 0;
            end
        end
    endtask

    task automatic stepModel(string tag, logic [3:0] v, logic [3:0] l, logic [63:0] d, logic f);
        applyStimulus(v, l, d, f);
        modelCheck(tag);
    endtask

    // Every producer is valid during reset, so a zero output shows that the
    // reset state holds against live requests.
    task automatic resetDut();
        resetn_i     = 1'b0;
        req_valid_i  = 4'hF;
        req_last_i   = 4'h0;
        req_data_i   = {$urandom, $urandom};
        fifo_wfull_i = 1'b0;
        #1;
        checkOutput("reset.grant", 32'(grant_o), 32'h0);
        checkOutput("reset.ready", 32'(req_ready_o), 32'h0);
        checkOutput("reset.wrEn",  32'(fifo_wr_en_o), 32'h0);
        checkOutput("reset.wdata", 32'(fifo_wdata_o), 32'h0);
        checkOutput("reset.busy",  32'(busy_o), 32'h0);
        modelReset();
        repeat (2) @(negedge clk_i);
        req_valid_i = 4'h0;
        resetn_i    = 1'b1;
    endtask

    initial begin
        int sent1;
        int sent3;
        int split;
        int ownerSeq[$];
        logic [FIFO_W-1:0] eWd;

        resetn_i     = 1'b0;
        req_valid_i  = '0;
        req_last_i   = '0;
        req_data_i   = '0;
        fifo_wfull_i = 1'b0;
        modelReset();

        // Rows 0-4: req0 sends A1,A2,A3. Rows 5-15: every producer sends
        // 1-beat packets, so grants rotate 0,1,2,3,0 with an idle cycle between.
        vecs[0]  = mkVec(1, 4'h1, 4'h0, packData(0, 16'hA1), 0, 4'h0, 4'h0, 0, 16'h0,  0);
        vecs[1]  = mkVec(0, 4'h1, 4'h0, packData(0, 16'hA1), 0, 4'h1, 4'h1, 1, 16'hA1, 1);
        vecs[2]  = mkVec(0, 4'h1, 4'h0, packData(0, 16'hA2), 0, 4'h1, 4'h1, 1, 16'hA2, 1);
        vecs[3]  = mkVec(0, 4'h1, 4'h1, packData(0, 16'hA3), 0, 4'h1, 4'h1, 1, 16'hA3, 1);
        vecs[4]  = mkVec(0, 4'h0, 4'h0, 64'h0,               0, 4'h0, 4'h0, 0, 16'h0,  0);
        vecs[5]  = mkVec(1, 4'hF, 4'hF, 64'h00B3_00B2_00B1_00B0, 0, 4'h0, 4'h0, 0, 16'h0,  0);
        vecs[6]  = mkVec(0, 4'hF, 4'hF, 64'h00B3_00B2_00B1_00B0, 0, 4'h1, 4'h1, 1, 16'hB0, 1);
        vecs[7]  = mkVec(0, 4'hF, 4'hF, 64'h00B3_00B2_00B1_00B0, 0, 4'h0, 4'h0, 0, 16'h0,  0);
        vecs[8]  = mkVec(0, 4'hF, 4'hF, 64'h00B3_00B2_00B1_00B0, 0, 4'h2, 4'h2, 1, 16'hB1, 1);
        vecs[9]  = mkVec(0, 4'hF, 4'hF, 64'h00B3_00B2_00B1_00B0, 0, 4'h0, 4'h0, 0, 16'h0,  0);
        vecs[10] = mkVec(0, 4'hF, 4'hF, 64'h00B3_00B2_00B1_00B0, 0, 4'h4, 4'h4, 1, 16'hB2, 1);
        vecs[11] = mkVec(0, 4'hF, 4'hF, 64'h00B3_00B2_00B1_00B0, 0, 4'h0, 4'h0, 0, 16'h0,  0);
        vecs[12] = mkVec(0, 4'hF, 4'hF, 64'h00B3_00B2_00B1_00B0, 0, 4'h8, 4'h8, 1, 16'hB3, 1);
        vecs[13] = mkVec(0, 4'hF, 4'hF, 64'h00B3_00B2_00B1_00B0, 0, 4'h0, 4'h0, 0, 16'h0,  0);
        vecs[14] = mkVec(0, 4'hF, 4'hF, 64'h00B3_00B2_00B1_00B0, 0, 4'h1, 4'h1, 1, 16'hB0, 1);
        vecs[15] = mkVec(0, 4'h0, 4'h0, 64'h0,                   0, 4'h0, 4'h0, 0, 16'h0,  0);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].rst) resetDut();
            if (i == 0) fifoCap.delete();
            applyStimulus(vecs[i].valid, vecs[i].last, vecs[i].data, vecs[i].full);
            eWd = (vecs[i].expGrant != 0) ? expWdata(oneHotIdx(vecs[i].expGrant), vecs[i].expPayload) : '0;
            checkOutput($sformatf("vec%0d.grant", i), 32'(grant_o), 32'(vecs[i].expGrant));
            checkOutput($sformatf("vec%0d.ready", i), 32'(req_ready_o), 32'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d.wrEn", i),  32'(fifo_wr_en_o), 32'(vecs[i].expWrEn));
            checkOutput($sformatf("vec%0d.wdata", i), 32'(fifo_wdata_o), 32'(eWd));
            checkOutput($sformatf("vec%0d.busy", i),  32'(busy_o), 32'(vecs[i].expBusy));
            captureBeat();
            if (i == 4) begin
                checkOutput("t1.fifoCount", 32'(fifoCap.size()), 32'd3);
                for (int k = 0; k < 3 && k < fifoCap.size(); k++) begin
                    checkOutput($sformatf("t1.fifo%0d", k), 32'(fifoCap[k]),
                                32'(expWdata(0, 16'(16'hA1 + k))));
                end
            end
        end

        // req2 holds the lock through 5 full cycles, then finishes.
        resetDut();
        stepModel("t3", 4'h4, 4'h0, packData(2, 16'h0C01), 1'b0);
        stepModel("t3", 4'h4, 4'h0, packData(2, 16'h0C01), 1'b0);
        for (int k = 0; k < 5; k++) begin
            stepModel("t3", 4'h4, 4'h0, packData(2, 16'h0C02), 1'b1);
            checkOutput("t3.stallReady", 32'(req_ready_o), 32'h0);
            checkOutput("t3.stallWrEn",  32'(fifo_wr_en_o), 32'h0);
            checkOutput("t3.stallGrant", 32'(grant_o), 32'h4);
        end
        stepModel("t3", 4'h4, 4'h4, packData(2, 16'h0C02), 1'b0);
        checkOutput("t3.resumeWrEn", 32'(fifo_wr_en_o), 32'h1);
        stepModel("t3", 4'h0, 4'h0, 64'h0, 1'b0);
        checkOutput("t3.released", 32'(grant_o), 32'h0);

        // req1 sends a 20-beat packet while req3 waits with one beat: req1
        // is cut after 16 beats, req3 goes next, req1 finishes afterwards.
        resetDut();
        sent1 = 0;
        sent3 = 0;
        ownerSeq.delete();
        for (int c = 0; c < 80 && !(sent1 == 20 && sent3 == 1); c++) begin
            stepModel("t4", {sent3 < 1, 1'b0, sent1 < 20, 1'b0},
                      {1'b1, 1'b0, sent1 == 19, 1'b0},
                      packData(1, 16'(16'h1000 + sent1)) | packData(3, 16'h3333), 1'b0);
            if (fifo_wr_en_o === 1'b1) begin
                if (grant_o == 4'h2) begin
                    sent1++;
                    ownerSeq.push_back(1);
                end else if (grant_o == 4'h8) begin
                    sent3++;
                    ownerSeq.push_back(3);
                end
            end
        end
        checkOutput("t4.done", 32'(sent1 == 20 && sent3 == 1), 32'h1);
        split = -1;
        for (int k = 0; k < ownerSeq.size(); k++) begin
            if (split < 0 && ownerSeq[k] == 3) split = k;
        end
        checkOutput("t4.splitPos", 32'(split), 32'd16);
        checkOutput("t4.total",    32'(ownerSeq.size()), 32'd21);

        // Reset asserted asynchronously during beat 3 of a 4-beat packet.
        resetDut();
        stepModel("t5", 4'h1, 4'h0, packData(0, 16'h5001), 1'b0);
        stepModel("t5", 4'h1, 4'h0, packData(0, 16'h5001), 1'b0);
        stepModel("t5", 4'h1, 4'h0, packData(0, 16'h5002), 1'b0);
        @(negedge clk_i);
        req_data_i = packData(0, 16'h5003);
        #1;
        checkOutput("t5.preResetWrEn", 32'(fifo_wr_en_o), 32'h1);
        #2;
        resetn_i = 1'b0;
        #1;
        checkOutput("t5.rstGrant", 32'(grant_o), 32'h0);
        checkOutput("t5.rstReady", 32'(req_ready_o), 32'h0);
        checkOutput("t5.rstWrEn",  32'(fifo_wr_en_o), 32'h0);
        checkOutput("t5.rstWdata", 32'(fifo_wdata_o), 32'h0);
        checkOutput("t5.rstBusy",  32'(busy_o), 32'h0);
        modelReset();
        @(negedge clk_i);
        req_valid_i = 4'h0;
        resetn_i    = 1'b1;
        stepModel("t5", 4'h5, 4'h5, packData(0, 16'h5100) | packData(2, 16'h5200), 1'b0);
        stepModel("t5", 4'h5, 4'h5, packData(0, 16'h5100) | packData(2, 16'h5200), 1'b0);
        checkOutput("t5.firstWinner", 32'(grant_o), 32'h1);

        // Source index tagging on the FIFO data.
        resetDut();
        stepModel("t6", 4'h8, 4'h8, packData(3, 16'h1234), 1'b0);
        stepModel("t6", 4'h8, 4'h8, packData(3, 16'h1234), 1'b0);
        checkOutput("t6.wdata", 32'(fifo_wdata_o), T6_EXP);

        // Randomized traffic against the reference model.
        resetDut();
        for (int c = 0; c < 600; c++) begin
            stepModel("rnd", 4'($urandom_range(0, 15)), 4'($urandom & $urandom),
                      {$urandom, $urandom}, $urandom_range(0, 4) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
